// File: rtl/edge_det_pkg.sv
// Shared types for the multi-channel edge detector: detect modes and the
// per-channel arming FSM states.
package edge_det_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    OFF  = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARM    = 2'b01,
    ACTIVE = 2'b10
  } state_e;
endpackage

// File: rtl/edge_det_chan.sv
// One detector channel: input synchronizer, IDLE/ARM/ACTIVE FSM, edge
// detect, registered pulse, sticky flag and saturating event counter.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  mode_e            mode,
  input  logic             clr,
  output logic             edge_pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] count
);
  logic s;
  logic warm;

  // warm goes high once every synchronizer stage holds a real sample, so a
  // level present at reset release is loaded into p rather than seen as an edge.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s    = sig_in;
    assign warm = 1'b1;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] warm_q, warm_d;

    always_comb begin
      sync_d = SYNC_STAGES'({sync_q, sig_in});
      warm_d = SYNC_STAGES'({warm_q, 1'b1});
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
        warm_q <= '0;
      end else begin
        sync_q <= sync_d;
        warm_q <= warm_d;
      end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign warm = warm_q[SYNC_STAGES-1];
  end

  state_e           state_q, state_d;
  logic             p_q, p_d;
  logic             pulse_q, pulse_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise, fall, det;

  assign rise = s & ~p_q;
  assign fall = ~s & p_q;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    det     = 1'b0;
    case (state_q)
      IDLE: if (warm) state_d = ARM;
      ARM: begin
        state_d = ACTIVE;
        p_d     = s;
      end
      ACTIVE: begin
        p_d = s;
        case (mode)
          RISE:    det = rise;
          FALL:    det = fall;
          BOTH:    det = rise | fall;
          default: det = 1'b0;
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (mode == OFF) state_d = IDLE;

    pulse_d = det;
    // clr beats a simultaneous edge for count/sticky; the pulse still fires
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else begin
      cnt_d    = (det && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      sticky_d = sticky_q | det;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      p_q      <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign edge_pulse = pulse_q;
  assign sticky     = sticky_q;
  assign count      = cnt_q;
endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector top: one edge_det_chan per channel plus the
// any_edge OR-reduction.
module edge_detect_mc
  import edge_det_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic [MODE_W*NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH-1:0]       edge_pulse,
  output logic [NUM_CH-1:0]       sticky,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic                    any_edge
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_det_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in[i]),
      .mode      (mode_e'(mode[MODE_W*i +: MODE_W])),
      .clr       (clr[i]),
      .edge_pulse(edge_pulse[i]),
      .sticky    (sticky[i]),
      .count     (count[CNT_W*i +: CNT_W])
    );
  end

  assign any_edge = |edge_pulse;
endmodule
